photo_sensor_frontend: RTL and testbench
========================================

# photo_sensor_frontend

Conditioning stage directly upstream of the bank-queue occupancy counter. It takes the two raw photocell lines: `a_raw` at the entry gate and `b_raw` at the teller/exit gate. Each line is synchronized and debounced, and each completed beam-break (stable falling edge) becomes a single-cycle, clean event pulse. Pulses are gated against the counter's `full`/`empty` status, and simultaneous entry/exit events are serialized so the downstream counter never sees both in one cycle.

## Interface
- `DB_CYCLES`, default 4: consecutive cycles a synchronized level must persist before it is accepted. Legal range is 2..15; the debounce counter is 4 bits.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a_raw`  in  1  entry photocell. 1 = beam unbroken (idle), 0 = beam broken. Asynchronous.
- `b_raw`  in  1  exit photocell, same encoding. Asynchronous.
- `full`  in  1  occupancy counter is at capacity (7). Synchronous to `clk`.
- `empty`  in  1  occupancy counter is at 0. Synchronous to `clk`.
- `enter_pulse`  out  1  one-cycle strobe: one accepted arrival.
- `exit_pulse`  out  1  one-cycle strobe: one accepted departure.
- `enter_reject`  out  1  one-cycle strobe: arrival dropped because `full`.
- `exit_reject`  out  1  one-cycle strobe: departure dropped because `empty`.
- `a_stable`, `b_stable`  out  1 each  debounced sensor levels.
- `enter_total`  out  8  accepted arrivals since reset. Wraps 255 -> 0.

## Operation
- Synchronizer: two flops per sensor, reset value 1.
- Debounce, per sensor (4-bit counter `cnt`, stable level `stb`):
  - If the synchronized level equals `stb`, `cnt` clears to 0.
  - Otherwise `cnt` increments. On the edge where `cnt == DB_CYCLES-1` and the levels still differ, `stb` takes the synchronized level and `cnt` clears.
  - A glitch shorter than `DB_CYCLES` cycles restarts the count and never changes `stb`.
- Event detect: a `stb` transition 1->0 raises an internal event `ev_a` / `ev_b` for exactly one cycle. Transitions 0->1 produce nothing.
- Arbitration FSM, states IDLE and HOLD_ENTER:
  - IDLE, `ev_b` only: issue exit.
  - IDLE, `ev_a` only: issue enter.
  - IDLE, `ev_a` and `ev_b` together: issue exit this cycle and go to HOLD_ENTER.
  - HOLD_ENTER: issue the held enter next cycle and return to IDLE. A new `ev_b` cannot arrive in that cycle because `DB_CYCLES >= 2`.
- Issue rules:
  - Issuing an exit drives `exit_pulse` if `empty == 0`, otherwise `exit_reject`.
  - Issuing an enter drives `enter_pulse` if `full == 0`, otherwise `enter_reject`.
  - `full`/`empty` are sampled in the cycle the decision is made. For a held enter, that is the HOLD_ENTER cycle, which sees the status already updated by the preceding exit.
- `enter_total` increments on every `enter_pulse`, never on `enter_reject`.
- Within one cycle, `enter_pulse`/`enter_reject` are mutually exclusive, `exit_pulse`/`exit_reject` are mutually exclusive, and no enter strobe is ever concurrent with an exit strobe.

## Timing
- Reset (asynchronous assert, synchronous release via the registers) drives:
  - sync flops, `a_stable`, `b_stable` = 1;
  - `cnt` = 0;
  - FSM = IDLE;
  - all strobes = 0;
  - `enter_total` = 0.
- Reset mid-debounce discards the partial count. Reset in HOLD_ENTER drops the held enter.
- Latency: let edge k be the first edge that samples a new raw level. Then `stb` changes at edge k+`DB_CYCLES`+1, and the strobe is registered at edge k+`DB_CYCLES`+2. With the default this is edge k+6, and the strobe is high for that one cycle.
- A held enter is strobed exactly one cycle after its paired exit.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset state:** assert `reset`=0 with the raw lines toggling -> all strobes 0, both `*_stable`=1, `enter_total`=0. Release -> no strobe for at least 6 cycles.
- **Clean arrival:** `DB_CYCLES`=4, `full`=0; hold `a_raw`=0 from before edge k -> `enter_pulse`=1 only in the cycle after edge k+6, and `enter_total`=1.
- **Glitch reject:** drop `a_raw` for 3 cycles, then return it high -> no strobe and `a_stable` stays 1. Drop it for 4 cycles -> one `enter_pulse`.
- **Gating:** `full`=1 during an arrival -> `enter_reject`=1 and `enter_total` unchanged. `empty`=1 during a departure -> `exit_reject`=1 and no `exit_pulse`.
- **Simultaneous events:** drop `a_raw` and `b_raw` on the same edge with `empty`=0 and `full`=0 -> `exit_pulse` at edge k+6, `enter_pulse` at edge k+7, never both in one cycle.
- **Counter wrap:** 256 accepted arrivals -> `enter_total` returns to 0.

Source files
------------

// File: rtl/photo_sensor_frontend.sv
// Photocell conditioning: sync + debounce + falling-edge event, gated by full/empty, enter/exit serialized.
// Latency: strobe DB_CYCLES+2 edges after the raw level is first sampled; no backpressure, events never stall.

module photo_sensor_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    output logic stable,
    output logic fall
);

    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic [1:0] syncQ;
    logic [3:0] cnt;
    logic       stableDly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncQ <= 2'b11;
        end else begin
            syncQ <= {syncQ[0], rawIn};
        end
    end

    // Level must disagree with stable for DB_CYCLES consecutive edges before it is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 4'd0;
            stable <= 1'b1;
        end else if (syncQ[1] == stable) begin
            cnt <= 4'd0;
        end else if (cnt == DB_LAST) begin
            stable <= syncQ[1];
            cnt    <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stableDly <= 1'b1;
        end else begin
            stableDly <= stable;
        end
    end

    assign fall = stableDly & ~stable;

endmodule

module photo_sensor_frontend #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       full,
    input  logic       empty,
    output logic       enter_pulse,
    output logic       exit_pulse,
    output logic       enter_reject,
    output logic       exit_reject,
    output logic       a_stable,
    output logic       b_stable,
    output logic [7:0] enter_total
);

    typedef enum logic {
        IDLE       = 1'b0,
        HOLD_ENTER = 1'b1
    } arbState_t;

    arbState_t state;
    arbState_t nextState;
    logic      evA;
    logic      evB;
    logic      issueEnter;
    logic      issueExit;

    photo_sensor_debounce #(.DB_CYCLES(DB_CYCLES)) debounceA (
        .clk    (clk),
        .reset  (reset),
        .rawIn  (a_raw),
        .stable (a_stable),
        .fall   (evA)
    );

    photo_sensor_debounce #(.DB_CYCLES(DB_CYCLES)) debounceB (
        .clk    (clk),
        .reset  (reset),
        .rawIn  (b_raw),
        .stable (b_stable),
        .fall   (evB)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Exit wins a tie so the held enter sees the occupancy after the departure.
    always_comb begin
        nextState  = state;
        issueEnter = 1'b0;
        issueExit  = 1'b0;
        case (state)
            IDLE: begin
                if (evA && evB) begin
                    issueExit = 1'b1;
                    nextState = HOLD_ENTER;
                end else if (evB) begin
                    issueExit = 1'b1;
                end else if (evA) begin
                    issueEnter = 1'b1;
                end
            end
            HOLD_ENTER: begin
                issueEnter = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_pulse  <= 1'b0;
            enter_reject <= 1'b0;
            exit_pulse   <= 1'b0;
            exit_reject  <= 1'b0;
            enter_total  <= 8'd0;
        end else begin
            enter_pulse  <= issueEnter & ~full;
            enter_reject <= issueEnter & full;
            exit_pulse   <= issueExit & ~empty;
            exit_reject  <= issueExit & empty;
            if (issueEnter && !full) begin
                enter_total <= enter_total + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_photo_sensor_frontend.sv
// Directed bench for photo_sensor_frontend: exact-timing sequences plus a table of sensor scenarios.

module tb_photo_sensor_frontend;

    logic       clk;
    logic       reset;
    logic       a_raw;
    logic       b_raw;
    logic       full;
    logic       empty;
    logic       enter_pulse;
    logic       exit_pulse;
    logic       enter_reject;
    logic       exit_reject;
    logic       a_stable;
    logic       b_stable;
    logic [7:0] enter_total;

    int assertCount = 0;
    int failCount   = 0;

    photo_sensor_frontend #(.DB_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_raw        (a_raw),
        .b_raw        (b_raw),
        .full         (full),
        .empty        (empty),
        .enter_pulse  (enter_pulse),
        .exit_pulse   (exit_pulse),
        .enter_reject (enter_reject),
        .exit_reject  (exit_reject),
        .a_stable     (a_stable),
        .b_stable     (b_stable),
        .enter_total  (enter_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic dropA;
        logic dropB;
        int   lowCycles;
        logic fullV;
        logic emptyV;
        int   expEnP;
        int   expEnR;
        int   expExP;
        int   expExR;
        int   expDelta;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic arrive();
        @(negedge clk);
        a_raw = 1'b0;
        repeat (5) @(negedge clk);
        a_raw = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int enP, enR, exP, exR, overlap;
        logic [7:0] total0;
        logic anyStrobe;

        reset = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        full  = 1'b0;
        empty = 1'b0;

        //                dropA dropB low  full  empty enP enR exP exR delta
        vecs[0]  = '{1'b1, 1'b0, 3,  1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 4,  1'b0, 1'b0, 1, 0, 0, 0, 1};
        vecs[2]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1, 0, 0, 0, 1};
        vecs[3]  = '{1'b1, 1'b0, 8,  1'b1, 1'b0, 0, 1, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 6,  1'b0, 1'b0, 0, 0, 1, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 6,  1'b0, 1'b1, 0, 0, 0, 1, 0};
        vecs[6]  = '{1'b0, 1'b1, 3,  1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1'b1, 1'b1, 6,  1'b0, 1'b0, 1, 0, 1, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 6,  1'b1, 1'b1, 0, 1, 0, 1, 0};
        vecs[9]  = '{1'b1, 1'b1, 6,  1'b1, 1'b0, 0, 1, 1, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 2,  1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 4,  1'b0, 1'b0, 0, 0, 1, 0, 0};

        // Reset held while the raw lines toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_raw = i[0];
            b_raw = ~i[0];
        end
        check("rst_enter_pulse", enter_pulse, 0);
        check("rst_exit_pulse", exit_pulse, 0);
        check("rst_enter_reject", enter_reject, 0);
        check("rst_exit_reject", exit_reject, 0);
        check("rst_a_stable", a_stable, 1);
        check("rst_b_stable", b_stable, 1);
        check("rst_enter_total", enter_total, 0);
        a_raw = 1'b1;
        b_raw = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        anyStrobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            anyStrobe |= enter_pulse | exit_pulse | enter_reject | exit_reject;
        end
        check("post_reset_quiet", anyStrobe, 0);

        // Clean arrival: pulse exactly at edge k+6
        @(negedge clk);
        a_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("clean_enter_pulse_c%0d", i), enter_pulse, (i == 7) ? 1 : 0);
            if (i == 5) check("clean_a_stable_before", a_stable, 1);
            if (i == 6) check("clean_a_stable_after", a_stable, 0);
        end
        check("clean_enter_total", enter_total, 1);
        a_raw = 1'b1;
        repeat (12) @(negedge clk);

        // Simultaneous: exit at k+6, held enter at k+7
        @(negedge clk);
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("simul_exit_pulse_c%0d", i), exit_pulse, (i == 7) ? 1 : 0);
            check($sformatf("simul_enter_pulse_c%0d", i), enter_pulse, (i == 8) ? 1 : 0);
        end
        check("simul_enter_total", enter_total, 2);
        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (12) @(negedge clk);

        // Table of scenarios
        foreach (vecs[v]) begin
            full   = vecs[v].fullV;
            empty  = vecs[v].emptyV;
            total0 = enter_total;
            enP = 0; enR = 0; exP = 0; exR = 0; overlap = 0;
            @(negedge clk);
            if (vecs[v].dropA) a_raw = 1'b0;
            if (vecs[v].dropB) b_raw = 1'b0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                enP += int'(enter_pulse);
                enR += int'(enter_reject);
                exP += int'(exit_pulse);
                exR += int'(exit_reject);
                if (((enter_pulse | enter_reject) & (exit_pulse | exit_reject)) ||
                    (enter_pulse & enter_reject) || (exit_pulse & exit_reject))
                    overlap++;
                if (i == vecs[v].lowCycles) begin
                    a_raw = 1'b1;
                    b_raw = 1'b1;
                end
            end
            check($sformatf("vec%0d_enter_pulses", v), enP, vecs[v].expEnP);
            check($sformatf("vec%0d_enter_rejects", v), enR, vecs[v].expEnR);
            check($sformatf("vec%0d_exit_pulses", v), exP, vecs[v].expExP);
            check($sformatf("vec%0d_exit_rejects", v), exR, vecs[v].expExR);
            check($sformatf("vec%0d_overlap", v), overlap, 0);
            check($sformatf("vec%0d_total_delta", v), 32'(enter_total - total0), vecs[v].expDelta);
            check($sformatf("vec%0d_a_stable_idle", v), a_stable, 1);
        end
        full  = 1'b0;
        empty = 1'b0;

        // Reset while holding an enter drops it
        @(negedge clk);
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int i = 1; i <= 7; i++) @(negedge clk);
        check("hold_exit_pulse", exit_pulse, 1);
        reset = 1'b0;
        @(negedge clk);
        check("hold_enter_dropped", enter_pulse, 0);
        check("hold_total_cleared", enter_total, 0);
        a_raw = 1'b1;
        b_raw = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        anyStrobe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            anyStrobe |= enter_pulse | exit_pulse | enter_reject | exit_reject;
        end
        check("hold_no_late_strobe", anyStrobe, 0);

        // Counter wrap
        for (int n = 0; n < 255; n++) arrive();
        check("wrap_total_255", enter_total, 255);
        arrive();
        check("wrap_total_0", enter_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
